// File: rtl/mem_if_pkg.sv
// Shared definitions for nanorv32 native memory interface initiators.
//   state_t      : copy-engine FSM states
//   WSTRB_READ   : write-strobe value that marks a read request
//   WSTRB_WORD   : write-strobe value for a full 32-bit word write
//   WORD_BYTES   : address stride between consecutive words
package mem_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT
    } state_t;

    localparam logic [3:0]  WSTRB_READ = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for a single bus transaction.
//   clk      in  clock
//   resetn   in  synchronous active-low reset
//   clear    in  hold the count at zero (asserted outside the wait states)
//   enable   in  count one cycle of waiting
//   expired  out high once TIMEOUT_CYC waiting cycles have been counted;
//                never asserted when TIMEOUT_CYC is 0
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count only needs to reach TIMEOUT_CYC-1: expiry is judged on the
    // edge that would have counted the last waiting cycle.
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYC != 0) && (cnt == LAST);

endmodule

// File: rtl/mem_dma_initiator.sv
// Word-by-word memory copy engine mastering the nanorv32 native memory bus.
//   clk, resetn           clock, synchronous active-low reset
//   start                 begin a copy (ignored while busy or during done)
//   abort                 end the copy after the current bus transaction
//   src_addr, dst_addr    first source/destination byte address
//   len_words             number of 32-bit words to copy
//   busy, done, error     copy in progress / end-of-copy pulse / sticky failure
//   words_done            words fully written in the current or last copy
//   mem_valid ... mem_rdata  native memory interface, initiator side
module mem_dma_initiator
    import mem_if_pkg::*;
#(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      buf_q;
    logic             abort_pend;
    logic             in_wait;
    logic             timer_expired;
    logic [LEN_W-1:0] wd_next;

    assign mem_instr = 1'b0;
    assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
    assign wd_next   = words_done + LEN_W'(1);

    mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            buf_q      <= '0;
            abort_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A start landing on the done cycle belongs to the copy
                    // that just ended and is dropped.
                    if (start && !done) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= len_words;
                        error      <= 1'b0;
                        words_done <= '0;
                        abort_pend <= 1'b0;
                        if (!is_word_aligned(src_addr) || !is_word_aligned(dst_addr)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else if (len_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= RD_ISSUE;
                        end
                    end
                end

                RD_ISSUE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        mem_addr  <= src_q;
                        mem_wstrb <= WSTRB_READ;
                        mem_valid <= 1'b1;
                        state     <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (mem_ready) begin
                        buf_q     <= mem_rdata;
                        mem_valid <= 1'b0;
                        if (abort_pend || abort) begin
                            abort_pend <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= WR_ISSUE;
                        end
                    end else if (timer_expired) begin
                        mem_valid  <= 1'b0;
                        error      <= 1'b1;
                        abort_pend <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end

                WR_ISSUE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        mem_addr  <= dst_q;
                        mem_wdata <= buf_q;
                        mem_wstrb <= WSTRB_WORD;
                        mem_valid <= 1'b1;
                        state     <= WR_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        words_done <= wd_next;
                        src_q      <= src_q + WORD_BYTES;
                        dst_q      <= dst_q + WORD_BYTES;
                        if ((wd_next == len_q) || abort_pend || abort) begin
                            abort_pend <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end else if (timer_expired) begin
                        mem_valid  <= 1'b0;
                        error      <= 1'b1;
                        abort_pend <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma_initiator.sv
// Self-checking bench for mem_dma_initiator: a sparse word memory responder
// with programmable ready delay, an expected-transaction queue built from the
// copy rules, and directed plus randomized copies.
module tb_mem_dma_initiator;

    localparam int unsigned LEN_W = 16;
    localparam int unsigned TMO   = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy, done, error;
    logic [LEN_W-1:0] words_done;
    logic             mem_valid, mem_instr;
    logic             mem_ready = 1'b0;
    logic [31:0]      mem_addr, mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata = '0;

    mem_dma_initiator #(
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic [31:0] mem [bit [31:0]];
    txn_t        exp_q[$];
    logic [31:0] src_vals[$];

    int          resp_delay = 0;
    bit          resp_dead = 1'b0;
    int          wcnt = 0;
    bit          have_prev = 1'b0;
    logic [67:0] prev_fields = '0;

    // Responder and bus monitor; everything happens on the falling edge so the
    // DUT samples settled values on the rising edge.
    initial begin : responder
        txn_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_ready = 1'b0;
                wcnt      = 0;
                have_prev = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                have_prev = 1'b0;
                check("valid_gap", 68'(mem_valid), 68'd0);
            end else if (mem_valid) begin
                if (have_prev)
                    check("req_stable", {mem_addr, mem_wdata, mem_wstrb}, prev_fields);
                prev_fields = {mem_addr, mem_wdata, mem_wstrb};
                have_prev   = 1'b1;
                wcnt++;
                // Seen on wcnt==1; ready sampled by the DUT resp_delay+2 edges
                // after the request went valid.
                if (!resp_dead && wcnt == resp_delay + 2) begin
                    wcnt = 0;
                    check("txn_pending", 68'(exp_q.size() != 0), 68'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("txn", {mem_addr, mem_wstrb, (mem_wstrb == 4'hF) ? mem_wdata : 32'h0},
                              {e.addr, e.wstrb, e.wdata});
                    end
                    if (mem_wstrb == 4'hF)
                        mem[mem_addr] = mem_wdata;
                    else
                        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
                    mem_ready = 1'b1;
                end
            end else begin
                wcnt      = 0;
                have_prev = 1'b0;
            end
        end
    end

    task automatic preload(input logic [31:0] s, input logic [31:0] d, input int n, input bit fixed);
        logic [31:0] v;
        src_vals.delete();
        for (int i = 0; i < n; i++) begin
            v = fixed ? 32'h1111_1111 * 32'(i + 1) : $urandom;
            mem[s + 32'(i * 4)] = v;
            src_vals.push_back(v);
            mem[d + 32'(i * 4)] = 32'hA5A5_0000 | 32'(i);
        end
    endtask

    // Expected bus order: read word i, write word i; optionally one trailing
    // read that an abort leaves without its write.
    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int nw, input bit extra_read);
        txn_t t;
        for (int i = 0; i < nw; i++) begin
            t.addr = s + 32'(i * 4); t.wstrb = 4'h0; t.wdata = 32'h0;
            exp_q.push_back(t);
            t.addr = d + 32'(i * 4); t.wstrb = 4'hF; t.wdata = src_vals[i];
            exp_q.push_back(t);
        end
        if (extra_read) begin
            t.addr = s + 32'(nw * 4); t.wstrb = 4'h0; t.wdata = 32'h0;
            exp_q.push_back(t);
        end
    endtask

    // edges: rising edges from the one that accepts start to the one that sets done.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input int abort_at,
                       output int edges, output int valid_cycles);
        bit hit;
        bit aborted;
        hit = 1'b0;
        aborted = 1'b0;
        edges = -1;
        valid_cycles = 0;
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = LEN_W'(n); start = 1'b1;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (mem_valid) valid_cycles++;
            if (abort_at >= 0 && !aborted && mem_valid && mem_wstrb == 4'h0 &&
                mem_addr == s + 32'(abort_at * 4)) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            if (done) begin
                hit = 1'b1;
                edges = k - 1;
                check("busy_at_done", 68'(busy), 68'd0);
                break;
            end
        end
        check("done_seen", 68'(hit), 68'd1);
        @(negedge clk);
        abort = 1'b0;
        check("done_pulse", 68'(done), 68'd0);
    endtask

    task automatic check_dst(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++)
            check("dst_word", 68'(mem[d + 32'(i * 4)]), 68'(src_vals[i]));
    endtask

    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int delay, input bit fixed);
        int edges, vc;
        resp_delay = delay;
        preload(s, d, n, fixed);
        expect_copy(s, d, n, 1'b0);
        run(s, d, n, -1, edges, vc);
        check("words_done", 68'(words_done), 68'(n));
        check("error", 68'(error), 68'd0);
        check("latency", 68'(edges), 68'(n * 2 * (3 + delay)));
        check_dst(d, n);
        check("exp_q_empty", 68'(exp_q.size()), 68'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int edges, vc;
        logic [31:0] s, d;

        repeat (3) @(negedge clk);
        check("rst_busy",  68'(busy), 68'd0);
        check("rst_done",  68'(done), 68'd0);
        check("rst_error", 68'(error), 68'd0);
        check("rst_wd",    68'(words_done), 68'd0);
        check("rst_valid", 68'(mem_valid), 68'd0);
        check("rst_bus",   {mem_addr, mem_wdata, mem_wstrb}, 68'd0);
        check("rst_instr", 68'(mem_instr), 68'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Reference copy with the fixed pattern, single-cycle responder.
        do_copy(32'h0000_0100, 32'h0000_0800, 4, 0, 1'b1);

        // Zero length: done in the following cycle, no traffic.
        run(32'h0000_0100, 32'h0000_0800, 0, -1, edges, vc);
        check("len0_latency", 68'(edges), 68'd0);
        check("len0_valid",   68'(vc), 68'd0);
        check("len0_error",   68'(error), 68'd0);

        // A start presented in the done cycle is dropped.
        @(negedge clk);
        src_addr = 32'h0000_0100; len_words = '0; start = 1'b1;
        @(negedge clk);
        check("dc_done", 68'(done), 68'd1);
        src_addr = 32'h0000_0103; len_words = LEN_W'(2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("dc_ignored_done", 68'(done), 68'd0);
        check("dc_ignored_err",  68'(error), 68'd0);
        check("dc_ignored_busy", 68'(busy), 68'd0);

        // Misaligned source: error, done next cycle, no traffic.
        run(32'h0000_0102, 32'h0000_0800, 4, -1, edges, vc);
        check("mis_latency", 68'(edges), 68'd0);
        check("mis_valid",   68'(vc), 68'd0);
        check("mis_error",   68'(error), 68'd1);
        check("mis_wd",      68'(words_done), 68'd0);

        // Slow responder.
        do_copy(32'h0000_0200, 32'h0000_0900, 2, 5, 1'b0);

        // Abort during the second word's read wait.
        resp_delay = 0;
        preload(32'h0000_3000, 32'h0000_4000, 8, 1'b0);
        expect_copy(32'h0000_3000, 32'h0000_4000, 1, 1'b1);
        run(32'h0000_3000, 32'h0000_4000, 8, 1, edges, vc);
        check("abort_wd",     68'(words_done), 68'd1);
        check("abort_error",  68'(error), 68'd0);
        check("abort_word0",  68'(mem[32'h0000_4000]), 68'(src_vals[0]));
        check("abort_nowr1",  68'(mem[32'h0000_4004]), 68'(32'hA5A5_0001));
        check("abort_q",      68'(exp_q.size()), 68'd0);
        exp_q.delete();

        // Abort while idle does nothing.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_done", 68'(done), 68'd0);
        check("idle_abort_busy", 68'(busy), 68'd0);

        // Responder never answers: timeout after TMO cycles of mem_valid.
        resp_dead = 1'b1;
        run(32'h0000_5000, 32'h0000_6000, 1, -1, edges, vc);
        check("tmo_valid_cycles", 68'(vc), 68'(TMO));
        check("tmo_latency",      68'(edges), 68'(TMO + 1));
        check("tmo_error",        68'(error), 68'd1);
        check("tmo_wd",           68'(words_done), 68'd0);
        check("tmo_valid_low",    68'(mem_valid), 68'd0);
        resp_dead = 1'b0;
        do_copy(32'h0000_5000, 32'h0000_6000, 3, 1, 1'b0);

        // Source address wraps through zero.
        do_copy(32'hFFFF_FFF8, 32'h0000_7000, 3, 1, 1'b0);

        // Randomized copies.
        for (int it = 0; it < 6; it++) begin
            s = 32'h0010_0000 + ($urandom_range(0, 1023) << 2);
            d = 32'h0020_0000 + ($urandom_range(0, 1023) << 2);
            do_copy(s, d, $urandom_range(1, 6), $urandom_range(0, 3), 1'b0);
        end

        // Reset in the middle of a copy forces the reset values.
        resp_delay = 2;
        preload(32'h0000_8000, 32'h0000_9000, 4, 1'b0);
        expect_copy(32'h0000_8000, 32'h0000_9000, 4, 1'b0);
        @(negedge clk);
        src_addr = 32'h0000_8000; dst_addr = 32'h0000_9000; len_words = LEN_W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 68'(mem_valid), 68'd0);
        check("mid_rst_busy",  68'(busy), 68'd0);
        check("mid_rst_wd",    68'(words_done), 68'd0);
        check("mid_rst_bus",   {mem_addr, mem_wdata, mem_wstrb}, 68'd0);
        resetn = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("post_rst_busy", 68'(busy), 68'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
